dff_pipe: RTL and testbench

- Parametrised, back-pressurable register pipeline. It replaces chains of plain D flip-flops wherever a bus path needs retiming.
- DEPTH stages of DW-bit data, each stage with a valid bit and a valid/ready handshake.
- Full throughput of one beat per cycle with no bubbles. Used for retiming AHB-side and APB-side datapaths in the bridge.

---
 rtl/dff_pkg.sv | 19 +
 rtl/dff_pipe_stage.sv | 47 ++++
 rtl/dff_pipe.sv | 104 ++++++++++
 tb/tb_dff_pipe.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_pkg.sv
// Shared constants and parameter-checking helpers for the dff_pipe register pipeline.
package dff_pkg;

  localparam int DFF_PIPE_MAX_DEPTH = 16;

  // Constant function so CW can be validated at elaboration time.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One DW-bit valid/ready register slice of dff_pipe.
// Optional synchronous clear input when DFF_PIPE_FLUSH_EN is defined.
module dff_pipe_stage
  import dff_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef DFF_PIPE_FLUSH_EN
  input  logic          flush,
`endif
  input  logic [DW-1:0] up_data,
  input  logic          up_vld,
  output logic          up_rdy,
  output logic [DW-1:0] dn_data,
  output logic          dn_vld,
  input  logic          dn_rdy
);

  logic clear;

`ifdef DFF_PIPE_FLUSH_EN
  assign clear = flush;
`else
  assign clear = 1'b0;
`endif

  // Slot is free when empty or when its beat leaves this cycle; a clear blocks loading.
  assign up_rdy = (!dn_vld | dn_rdy) & !clear;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dn_vld  <= 1'b0;
      dn_data <= '0;
    end else if (clear) begin
      dn_vld <= 1'b0;
    end else if (up_rdy) begin
      dn_vld <= up_vld;
      // A bubble advances the valid bit only, so data toggles only on real beats.
      if (up_vld) begin
        dn_data <= up_data;
      end
    end
  end

endmodule

// File: rtl/dff_pipe.sv
// Back-pressurable DEPTH-stage register pipeline with occupancy count.
// Optional flush input when DFF_PIPE_FLUSH_EN is defined.
module dff_pipe
  import dff_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 2,
  parameter int CW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef DFF_PIPE_FLUSH_EN
  input  logic          flush,
`endif
  input  logic [DW-1:0] din,
  input  logic          din_vld,
  output logic          din_rdy,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  input  logic          dout_rdy,
  output logic [CW-1:0] occ
);

  if (DW < 1) begin : g_bad_dw
    $error("dff_pipe: DW must be at least 1");
  end
  if (DEPTH < 1 || DEPTH > DFF_PIPE_MAX_DEPTH) begin : g_bad_depth
    $error("dff_pipe: DEPTH out of range 1..16");
  end
  if (CW < clog2(DEPTH + 1)) begin : g_bad_cw
    $error("dff_pipe: CW too narrow for DEPTH");
  end

  logic clear;
  logic accept;
  logic emit;

`ifdef DFF_PIPE_FLUSH_EN
  assign clear = flush;
`else
  assign clear = 1'b0;
`endif

  // Each stage keeps its own ready net so the backward chain stays a plain path of separate signals.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [DW-1:0] up_data;
    logic          up_vld;
    logic          dn_rdy;
    logic [DW-1:0] data;
    logic          vld;
    logic          rdy;

    if (k == 0) begin : g_first
      assign up_data = din;
      assign up_vld  = din_vld;
    end else begin : g_mid
      assign up_data = g_stage[k-1].data;
      assign up_vld  = g_stage[k-1].vld;
    end

    if (k == DEPTH - 1) begin : g_last
      assign dn_rdy = dout_rdy;
    end else begin : g_inner
      assign dn_rdy = g_stage[k+1].rdy;
    end

    dff_pipe_stage #(
      .DW (DW)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
`ifdef DFF_PIPE_FLUSH_EN
      .flush   (flush),
`endif
      .up_data (up_data),
      .up_vld  (up_vld),
      .up_rdy  (rdy),
      .dn_data (data),
      .dn_vld  (vld),
      .dn_rdy  (dn_rdy)
    );
  end

  assign din_rdy  = g_stage[0].rdy;
  assign dout     = g_stage[DEPTH-1].data;
  assign dout_vld = g_stage[DEPTH-1].vld;

  assign accept = din_vld & din_rdy;
  assign emit   = dout_vld & dout_rdy;

  // Occupancy tracks accepts minus emits; a flush empties the pipe and drops any emit that edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ <= '0;
    end else if (clear) begin
      occ <= '0;
    end else if (accept && !emit) begin
      occ <= occ + CW'(1);
    end else if (emit && !accept) begin
      occ <= occ - CW'(1);
    end
  end

endmodule

// File: tb/tb_dff_pipe.sv
// Directed self-checking bench for dff_pipe: DEPTH=2 and DEPTH=3 instances share stimulus.
// Flush scenario is included when DFF_PIPE_FLUSH_EN is defined.
module tb_dff_pipe;

  logic        clk;
  logic        rstN;
  logic        flush;
  logic [31:0] din;
  logic        dinVld;
  logic        doutRdy;

  logic [31:0] dout2;
  logic        doutVld2;
  logic        dinRdy2;
  logic [4:0]  occ2;

  logic [31:0] dout3;
  logic        doutVld3;
  logic        dinRdy3;
  logic [4:0]  occ3;

  int checks;
  int errors;

  dff_pipe #(.DW(32), .DEPTH(2), .CW(5)) dut2 (
    .clk      (clk),
    .rst_n    (rstN),
`ifdef DFF_PIPE_FLUSH_EN
    .flush    (flush),
`endif
    .din      (din),
    .din_vld  (dinVld),
    .din_rdy  (dinRdy2),
    .dout     (dout2),
    .dout_vld (doutVld2),
    .dout_rdy (doutRdy),
    .occ      (occ2)
  );

  dff_pipe #(.DW(32), .DEPTH(3), .CW(5)) dut3 (
    .clk      (clk),
    .rst_n    (rstN),
`ifdef DFF_PIPE_FLUSH_EN
    .flush    (flush),
`endif
    .din      (din),
    .din_vld  (dinVld),
    .din_rdy  (dinRdy3),
    .dout     (dout3),
    .dout_vld (doutVld3),
    .dout_rdy (doutRdy),
    .occ      (occ3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rstN    = 1'b0;
    dinVld  = 1'b1;
    din     = 32'hDEAD_BEEF;
    doutRdy = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (doutVld2 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_dout_vld cycle %0d got %b want 0", c, doutVld2);
      end
      checks++;
      if (dout2 !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_dout cycle %0d got %h want 00000000", c, dout2);
      end
      checks++;
      if (occ2 !== 5'd0) begin
        errors++;
        $display("[TB] FAIL reset_occ cycle %0d got %0d want 0", c, occ2);
      end
    end
    rstN   = 1'b1;
    dinVld = 1'b0;
    #1;
    checks++;
    if (dinRdy2 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_din_rdy got %b want 1", dinRdy2);
    end
  endtask

  task automatic test_stream;
    doutRdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din    = 32'(i + 1);
      dinVld = 1'b1;
      #1;
      checks++;
      if (dinRdy2 !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stream_din_rdy beat %0d got %b want 1", i + 1, dinRdy2);
      end
      tick();
      if (i == 0) begin
        checks++;
        if (doutVld2 !== 1'b0 || occ2 !== 5'd1) begin
          errors++;
          $display("[TB] FAIL stream_first vld/occ got %b/%0d want 0/1", doutVld2, occ2);
        end
      end else begin
        checks++;
        if (doutVld2 !== 1'b1 || dout2 !== 32'(i) || occ2 !== 5'd2) begin
          errors++;
          $display("[TB] FAIL stream_out vld/dout/occ got %b/%0d/%0d want 1/%0d/2",
                   doutVld2, dout2, occ2, i);
        end
      end
    end
    dinVld = 1'b0;
    tick();
    checks++;
    if (doutVld2 !== 1'b1 || dout2 !== 32'd8 || occ2 !== 5'd1) begin
      errors++;
      $display("[TB] FAIL stream_last vld/dout/occ got %b/%0d/%0d want 1/8/1", doutVld2, dout2, occ2);
    end
    tick();
    checks++;
    if (doutVld2 !== 1'b0 || occ2 !== 5'd0) begin
      errors++;
      $display("[TB] FAIL stream_drain vld/occ got %b/%0d want 0/0", doutVld2, occ2);
    end
  endtask

  task automatic test_fill_stall;
    logic [31:0] beats [4];
    beats[0] = 32'hA000_0000;
    beats[1] = 32'hA000_0001;
    beats[2] = 32'hA000_0002;
    beats[3] = 32'hA000_0003;
    doutRdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      din    = beats[i];
      dinVld = 1'b1;
      #1;
      checks++;
      if (dinRdy2 !== 1'b1) begin
        errors++;
        $display("[TB] FAIL fill_accept beat %0d got din_rdy %b want 1", i, dinRdy2);
      end
      tick();
    end
    din = beats[2];
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (dinRdy2 !== 1'b0 || occ2 !== 5'd2 || doutVld2 !== 1'b1 || dout2 !== beats[0]) begin
        errors++;
        $display("[TB] FAIL stall_hold cycle %0d rdy/occ/vld/dout got %b/%0d/%b/%h want 0/2/1/%h",
                 c, dinRdy2, occ2, doutVld2, dout2, beats[0]);
      end
      tick();
    end
    doutRdy = 1'b1;
    #1;
    checks++;
    if (dinRdy2 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_release_rdy got %b want 1", dinRdy2);
    end
    tick();
    din = beats[3];
    for (int k = 1; k < 4; k++) begin
      checks++;
      if (doutVld2 !== 1'b1 || dout2 !== beats[k]) begin
        errors++;
        $display("[TB] FAIL stall_order idx %0d vld/dout got %b/%h want 1/%h", k, doutVld2, dout2, beats[k]);
      end
      if (k == 1) begin
        tick();
        dinVld = 1'b0;
      end else begin
        tick();
      end
    end
    checks++;
    if (doutVld2 !== 1'b0 || occ2 !== 5'd0) begin
      errors++;
      $display("[TB] FAIL stall_drain vld/occ got %b/%0d want 0/0", doutVld2, occ2);
    end
  endtask

  task automatic test_back_to_back;
    doutRdy = 1'b0;
    dinVld  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      din = 32'hB000_0000 + 32'(i);
      tick();
    end
    checks++;
    if (occ2 !== 5'd2) begin
      errors++;
      $display("[TB] FAIL full_occ got %0d want 2", occ2);
    end
    doutRdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = 32'hB000_0002 + 32'(i);
      #1;
      checks++;
      if (doutVld2 !== 1'b1 || dout2 !== 32'hB000_0000 + 32'(i) || dinRdy2 !== 1'b1) begin
        errors++;
        $display("[TB] FAIL full_emit idx %0d vld/dout/rdy got %b/%h/%b want 1/%h/1",
                 i, doutVld2, dout2, dinRdy2, 32'hB000_0000 + 32'(i));
      end
      tick();
      checks++;
      if (occ2 !== 5'd2) begin
        errors++;
        $display("[TB] FAIL full_occ_steady idx %0d got %0d want 2", i, occ2);
      end
    end
    dinVld = 1'b0;
    checks++;
    if (dout2 !== 32'hB000_0005) begin
      errors++;
      $display("[TB] FAIL full_tail0 got %h want b0000005", dout2);
    end
    tick();
    checks++;
    if (dout2 !== 32'hB000_0006 || occ2 !== 5'd1) begin
      errors++;
      $display("[TB] FAIL full_tail1 dout/occ got %h/%0d want b0000006/1", dout2, occ2);
    end
    tick();
    checks++;
    if (occ2 !== 5'd0 || doutVld2 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_empty occ/vld got %0d/%b want 0/0", occ2, doutVld2);
    end
  endtask

  task automatic test_bubble;
    logic [31:0] inData [13];
    logic        inVld  [13];
    logic        expVld;
    logic [31:0] expData;
    rstN   = 1'b0;
    dinVld = 1'b0;
    tick();
    rstN    = 1'b1;
    doutRdy = 1'b1;
    for (int j = 0; j < 13; j++) begin
      inVld[j]  = 1'b0;
      inData[j] = 32'h0;
    end
    for (int j = 0; j < 5; j++) begin
      inVld[j]  = 1'b1;
      inData[j] = 32'(j + 1);
    end
    inData[5] = 32'd99;
    for (int j = 6; j < 9; j++) begin
      inVld[j]  = 1'b1;
      inData[j] = 32'(j);
    end
    for (int j = 0; j < 13; j++) begin
      din    = inData[j];
      dinVld = inVld[j];
      tick();
      expVld  = (j >= 2) ? inVld[j-2] : 1'b0;
      expData = (j >= 2) ? inData[j-2] : 32'h0;
      checks++;
      if (doutVld3 !== expVld || (expVld && dout3 !== expData)) begin
        errors++;
        $display("[TB] FAIL bubble cycle %0d vld/dout got %b/%0d want %b/%0d",
                 j, doutVld3, dout3, expVld, expData);
      end
    end
  endtask

`ifdef DFF_PIPE_FLUSH_EN
  task automatic test_flush;
    doutRdy = 1'b0;
    dinVld  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      din = 32'hC000_0000 + 32'(i);
      tick();
    end
    checks++;
    if (occ2 !== 5'd2) begin
      errors++;
      $display("[TB] FAIL flush_pre_occ got %0d want 2", occ2);
    end
    flush   = 1'b1;
    doutRdy = 1'b1;
    din     = 32'hC000_0002;
    #1;
    checks++;
    if (dinRdy2 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_din_rdy got %b want 0", dinRdy2);
    end
    tick();
    flush = 1'b0;
    dinVld = 1'b0;
    checks++;
    if (occ2 !== 5'd0 || doutVld2 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_clear occ/vld got %0d/%b want 0/0", occ2, doutVld2);
    end
    tick();
    tick();
    checks++;
    if (occ2 !== 5'd0 || doutVld2 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_no_accept occ/vld got %0d/%b want 0/0", occ2, doutVld2);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    rstN    = 1'b0;
    flush   = 1'b0;
    din     = 32'h0;
    dinVld  = 1'b0;
    doutRdy = 1'b0;
    test_reset();
    test_stream();
    test_fill_stall();
    test_back_to_back();
    test_bubble();
`ifdef DFF_PIPE_FLUSH_EN
    test_flush();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
